// File: rtl/qkv_proj_ctrl.sv
// Q/K/V projection sequencer: runs X*Wq, X*Wk, X*Wv on the shared SA and holds the results.
// Latency 3L+6 cycles start-to-O_QKV_VLD (L = SA start-to-valid); results held until I_QKV_ACK.
module qkv_proj_ctrl #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int M_DIM = 16,
    parameter int DIM   = 16,
    parameter int D_K   = 16
) (
    input  logic                                 I_CLK,
    input  logic                                 I_SYNC_RSTN,
    input  logic                                 I_PROJ_START,
    input  logic [DIM-1:0][M_DIM-1:0][D_W-1:0]   I_MAT_X,
    input  logic [M_DIM-1:0][D_K-1:0][D_W-1:0]   I_MAT_WQ,
    input  logic [M_DIM-1:0][D_K-1:0][D_W-1:0]   I_MAT_WK,
    input  logic [M_DIM-1:0][D_K-1:0][D_W-1:0]   I_MAT_WV,
    input  logic                                 I_SA_VLD,
    input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   I_SA_RESULT,
    output logic                                 O_SA_START,
    output logic                                 O_SA_CLEARN,
    output logic [SA_R-1:0][M_DIM-1:0][D_W-1:0]  O_MAT_1,
    output logic [M_DIM-1:0][SA_C-1:0][D_W-1:0]  O_MAT_2,
    output logic                                 O_BUSY,
    output logic                                 O_QKV_VLD,
    input  logic                                 I_QKV_ACK,
    output logic [DIM-1:0][D_K-1:0][D_W-1:0]     O_MAT_Q,
    output logic [DIM-1:0][D_K-1:0][D_W-1:0]     O_MAT_K,
    output logic [DIM-1:0][D_K-1:0][D_W-1:0]     O_MAT_V
);

    typedef enum logic [7:0] {
        IDLE   = 8'b0000_0001,
        CLR_Q  = 8'b0000_0010,
        CALC_Q = 8'b0000_0100,
        CLR_K  = 8'b0000_1000,
        CALC_K = 8'b0001_0000,
        CLR_V  = 8'b0010_0000,
        CALC_V = 8'b0100_0000,
        DONE   = 8'b1000_0000
    } state_t;

    state_t state;

    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RSTN) begin
            state       <= IDLE;
            O_SA_START  <= 1'b0;
            O_SA_CLEARN <= 1'b1;
            O_MAT_1     <= '0;
            O_MAT_2     <= '0;
            O_MAT_Q     <= '0;
            O_MAT_K     <= '0;
            O_MAT_V     <= '0;
            O_BUSY      <= 1'b0;
            O_QKV_VLD   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_PROJ_START) begin
                        O_MAT_1     <= I_MAT_X;
                        O_MAT_2     <= I_MAT_WQ;
                        O_SA_CLEARN <= 1'b0;
                        O_BUSY      <= 1'b1;
                        state       <= CLR_Q;
                    end else begin
                        O_MAT_1     <= '0;
                        O_MAT_2     <= '0;
                        O_SA_CLEARN <= 1'b1;
                    end
                end
                // Clear was asserted on entry; release it and kick the SA.
                CLR_Q, CLR_K, CLR_V: begin
                    O_SA_CLEARN <= 1'b1;
                    O_SA_START  <= 1'b1;
                    state       <= (state == CLR_Q) ? CALC_Q :
                                   (state == CLR_K) ? CALC_K : CALC_V;
                end
                CALC_Q: begin
                    O_SA_START <= 1'b0;
                    if (I_SA_VLD) begin
                        O_MAT_Q     <= I_SA_RESULT;
                        O_SA_CLEARN <= 1'b0;
                        O_MAT_2     <= I_MAT_WK;
                        state       <= CLR_K;
                    end
                end
                CALC_K: begin
                    O_SA_START <= 1'b0;
                    if (I_SA_VLD) begin
                        O_MAT_K     <= I_SA_RESULT;
                        O_SA_CLEARN <= 1'b0;
                        O_MAT_2     <= I_MAT_WV;
                        state       <= CLR_V;
                    end
                end
                CALC_V: begin
                    O_SA_START <= 1'b0;
                    if (I_SA_VLD) begin
                        O_MAT_V     <= I_SA_RESULT;
                        O_SA_CLEARN <= 1'b0;
                        O_MAT_1     <= '0;
                        O_MAT_2     <= '0;
                        O_QKV_VLD   <= 1'b1;
                        O_BUSY      <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (I_QKV_ACK) begin
                        O_QKV_VLD <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qkv_proj_ctrl.sv
// Randomised bench for qkv_proj_ctrl with a behavioural SA and an event-schedule reference model.
module tb_qkv_proj_ctrl;

    typedef logic [15:0][15:0][7:0] mat_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, proj_start, qkv_ack;
    mat_t mat_x, mat_wq, mat_wk, mat_wv;
    logic sa_vld_m, stray_vld, sa_vld;
    mat_t sa_res_m, stray_res, sa_result;
    logic sa_start, sa_clearn, busy, qkv_vld;
    mat_t mat_1, mat_2, mat_q, mat_k, mat_v;

    assign sa_vld    = sa_vld_m | stray_vld;
    assign sa_result = stray_vld ? stray_res : sa_res_m;

    qkv_proj_ctrl dut (
        .I_CLK(clk), .I_SYNC_RSTN(rstn), .I_PROJ_START(proj_start),
        .I_MAT_X(mat_x), .I_MAT_WQ(mat_wq), .I_MAT_WK(mat_wk), .I_MAT_WV(mat_wv),
        .I_SA_VLD(sa_vld), .I_SA_RESULT(sa_result),
        .O_SA_START(sa_start), .O_SA_CLEARN(sa_clearn),
        .O_MAT_1(mat_1), .O_MAT_2(mat_2),
        .O_BUSY(busy), .O_QKV_VLD(qkv_vld), .I_QKV_ACK(qkv_ack),
        .O_MAT_Q(mat_q), .O_MAT_K(mat_k), .O_MAT_V(mat_v)
    );

    int checks = 0;
    int errors = 0;

    function automatic mat_t mm(input mat_t a, input mat_t b);
        mat_t r;
        int   acc;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                acc = 0;
                for (int k = 0; k < 16; k++)
                    acc += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                r[i][j] = 8'(acc >>> 5);
            end
        return r;
    endfunction

    function automatic mat_t eye_m(input logic [7:0] v);
        mat_t r = '0;
        for (int i = 0; i < 16; i++) r[i][i] = v;
        return r;
    endfunction

    function automatic mat_t fill_m(input logic [7:0] v);
        mat_t r;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) r[i][j] = v;
        return r;
    endfunction

    function automatic mat_t rnd_m();
        mat_t r;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) r[i][j] = 8'($urandom);
        return r;
    endfunction

    function automatic mat_t ramp_m();
        mat_t r;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) r[i][j] = 8'(i + j);
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0b want=%0b", name, $time, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chkm(input string name, input mat_t act, input mat_t exp);
        int bi, bj;
        checks++;
        if (act !== exp) begin
            errors++;
            bi = 0; bj = 0;
            for (int i = 15; i >= 0; i--)
                for (int j = 15; j >= 0; j--)
                    if (act[i][j] !== exp[i][j]) begin bi = i; bj = j; end
            $display("FAIL %s t=%0t elem[%0d][%0d] got=%02h want=%02h",
                     name, $time, bi, bj, act[bi][bj], exp[bi][bj]);
        end
    endtask

    // Behavioural SA: latency sa_l from the cycle start is seen, result held
    // for sa_hold cycles, dropped whenever the clear is asserted.
    int sa_l = 5, sa_hold = 1;
    initial begin
        int   cnt, hold_left;
        bit   pend;
        pend = 0; cnt = 0; hold_left = 0;
        sa_vld_m = 1'b0; sa_res_m = '0;
        forever begin
            @(posedge clk); #1;
            if (sa_clearn === 1'b0) begin
                pend = 0; sa_vld_m = 1'b0;
            end else begin
                if (sa_vld_m) begin
                    if (hold_left > 0) hold_left--;
                    else sa_vld_m = 1'b0;
                end
                if (sa_start === 1'b1) begin
                    pend = 1; cnt = sa_l; sa_res_m = mm(mat_1, mat_2);
                end
                if (pend) begin
                    if (cnt == 0) begin
                        sa_vld_m = 1'b1; hold_left = sa_hold - 1; pend = 0;
                    end else cnt--;
                end
            end
        end
    end

    // Reference model: one run is a start edge s plus an SA latency L;
    // every output is a function of the offset d = edge - s.
    int   cyc = 0;
    int   ms = M_IDLE, m_s = 0, run_l = 0;
    bit   chk_en = 0;
    mat_t sx, swq, swk, swv;
    logic e_start, e_clearn, e_busy, e_vld;
    mat_t e_m1, e_m2, e_q, e_k, e_v;
    initial begin
        int d;
        e_clearn = 1'b1; e_q = '0; e_k = '0; e_v = '0;
        forever begin
            @(posedge clk);
            cyc++;
            d = cyc - m_s;
            if (!rstn) begin
                ms = M_IDLE; e_clearn = 1'b1; e_q = '0; e_k = '0; e_v = '0;
            end else if (ms == M_IDLE) begin
                if (proj_start) begin
                    ms = M_RUN; m_s = cyc; run_l = sa_l; e_clearn = 1'b0;
                    sx = mat_x; swq = mat_wq; swk = mat_wk; swv = mat_wv;
                end else e_clearn = 1'b1;
            end else if (ms == M_RUN) begin
                if (d == 1 || d == run_l + 3 || d == 2 * run_l + 5) e_clearn = 1'b1;
                if (d == run_l + 2)     begin e_q = mm(sx, swq); e_clearn = 1'b0; end
                if (d == 2 * run_l + 4) begin e_k = mm(sx, swk); e_clearn = 1'b0; end
                if (d == 3 * run_l + 6) begin e_v = mm(sx, swv); e_clearn = 1'b0; ms = M_DONE; end
            end else if (qkv_ack) ms = M_IDLE;
            d = cyc - m_s;
            e_busy  = (ms == M_RUN);
            e_vld   = (ms == M_DONE);
            e_start = (ms == M_RUN) && (d == 1 || d == run_l + 3 || d == 2 * run_l + 5);
            e_m1    = (ms == M_RUN) ? sx : '0;
            e_m2    = (ms != M_RUN) ? '0 : (d <= run_l + 1) ? swq :
                      (d <= 2 * run_l + 3) ? swk : swv;
            chk_en  = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("sa_start", sa_start, e_start);
                chk1("sa_clearn", sa_clearn, e_clearn);
                chk1("busy", busy, e_busy);
                chk1("qkv_vld", qkv_vld, e_vld);
                chkm("mat_1", mat_1, e_m1);
                chkm("mat_2", mat_2, e_m2);
                chkm("mat_q", mat_q, e_q);
                chkm("mat_k", mat_k, e_k);
                chkm("mat_v", mat_v, e_v);
            end
        end
    end

    int   st_q[$];
    int   vld_rise = 0;
    logic prev_vld = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (sa_start === 1'b1) st_q.push_back(cyc);
            if (qkv_vld === 1'b1 && prev_vld !== 1'b1) vld_rise = cyc;
            prev_vld = qkv_vld;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            stray_vld = stray ? 1'($urandom) : 1'b0;
            tick();
        end
        stray_vld = 1'b0;
    endtask

    task automatic run(input mat_t x, input mat_t wq, input mat_t wk, input mat_t wv,
                       input int l, input int hold, input int ack_dly, input bit stray,
                       input bit start_in_calc, input bit rst_in_calc, input bit ack_with_start);
        int  d, waited;
        bit  fin;
        sa_l = l; sa_hold = hold;
        mat_x = x; mat_wq = wq; mat_wk = wk; mat_wv = wv;
        proj_start = 1'b1;
        tick();
        proj_start = 1'b0;
        fin = 0; waited = 0;
        for (int n = 0; n < 400 && !fin; n++) begin
            d = cyc - m_s;
            stray_vld = 1'b0; proj_start = 1'b0;
            if (ms == M_RUN) begin
                if (stray && (d == 0 || d == l + 2 || d == 2 * l + 4)) stray_vld = 1'($urandom);
                if (start_in_calc && d == l + 3) proj_start = 1'b1;
                if (rst_in_calc && d == l + 3) begin
                    rstn = 1'b0; tick(); rstn = 1'b1; fin = 1;
                end
            end else if (ms == M_DONE) begin
                if (stray) stray_vld = 1'($urandom);
                if (waited == ack_dly) begin
                    qkv_ack = 1'b1; proj_start = ack_with_start;
                    tick();
                    qkv_ack = 1'b0; proj_start = 1'b0; stray_vld = 1'b0;
                    fin = 1;
                end
                waited++;
            end
            if (!fin) tick();
        end
        stray_vld = 1'b0; proj_start = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL run_timeout no completion within budget l=%0d", l);
        end
    endtask

    initial begin
        mat_t x_id, eye, eye2, zero, x10, x08;
        bit   aws;
        x_id = ramp_m(); eye = eye_m(8'h20); eye2 = eye_m(8'h40);
        zero = '0; x10 = fill_m(8'h10); x08 = fill_m(8'h08);
        rstn = 1'b0; proj_start = 1'b0; qkv_ack = 1'b0; stray_vld = 1'b0;
        stray_res = rnd_m(); mat_x = '0; mat_wq = '0; mat_wk = '0; mat_wv = '0;
        tick(); tick();
        chk1("rst_clearn", sa_clearn, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_vld", qkv_vld, 1'b0);
        chkm("rst_q", mat_q, zero);
        rstn = 1'b1;
        idle(4, 1);

        // Identity weights, ramp X, L=5: pulse timing pinned to literals.
        st_q.delete();
        run(x_id, eye, eye, eye, 5, 1, 4, 0, 0, 0, 0);
        chkint("t1_start_cnt", st_q.size(), 3);
        if (st_q.size() == 3) begin
            chkint("t1_start0", st_q[0] - m_s, 1);
            chkint("t1_start1", st_q[1] - m_s, 8);
            chkint("t1_start2", st_q[2] - m_s, 15);
        end
        chkint("t1_vld_rise", vld_rise - m_s, 21);
        chkint("t1_q35", int'(mat_q[3][5]), 8);
        chkint("t1_k1515", int'(mat_k[15][15]), 30);
        chkint("t1_v00", int'(mat_v[0][0]), 0);
        idle(2, 1);

        // Scaled weights, flat X.
        run(x10, eye, eye2, zero, 3, 2, 1, 1, 0, 0, 0);
        chkint("t2_q00", int'(mat_q[0][0]), 16);
        chkint("t2_k79", int'(mat_k[7][9]), 32);
        chkint("t2_v150", int'(mat_v[15][0]), 0);
        idle(3, 1);

        // Strays everywhere plus a start in CALC_K: one completion only.
        st_q.delete();
        run(rnd_m(), rnd_m(), rnd_m(), rnd_m(), 4, 2, 3, 1, 1, 0, 0);
        chkint("t3_start_cnt", st_q.size(), 3);
        idle(3, 1);

        // Reset mid CALC_K, late SA valid lands in IDLE, then a clean run.
        run(rnd_m(), rnd_m(), rnd_m(), rnd_m(), 3, 1, 0, 0, 0, 1, 0);
        chkm("t4_q_cleared", mat_q, zero);
        chk1("t4_busy", busy, 1'b0);
        idle(12, 0);
        run(x_id, eye, eye2, eye, 2, 1, 1, 0, 0, 0, 0);

        // Ack with start in DONE, then start re-asserted: second run overwrites.
        run(x_id, eye, eye, eye, 2, 1, 2, 0, 0, 0, 1);
        chk1("t5_not_busy", busy, 1'b0);
        run(x08, eye, eye, eye, 2, 1, 0, 0, 0, 0, 0);
        chkint("t5_q44", int'(mat_q[4][4]), 8);

        // Zero-latency SA with valid held.
        run(x_id, eye, eye2, eye, 0, 3, 1, 0, 0, 0, 0);
        chkint("t6_k22", int'(mat_k[2][2]), 8);

        aws = 0;
        for (int r = 0; r < 10; r++) begin
            if (!aws) idle(int'($urandom_range(0, 3)), 1);
            aws = 1'($urandom);
            run(rnd_m(), rnd_m(), rnd_m(), rnd_m(), int'($urandom_range(0, 6)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1,
                1'($urandom), 1'b0, aws);
        end
        idle(4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
